// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq
// Multi-cycle signed matrix ALU. A command (op, size, A, B, scalar) is latched
// on an accepted start, then executed one result element per cycle (one MAC
// per cycle for multiply). Every result is saturated to W bits.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   start   request pulse, accepted in IDLE or DONE
//   op      000 add, 001 sub, 010 mult, 011 scalar, 100 det, 101 transpose,
//           110 opposite, 111 clear
//   size    active dimension n (1..MAX_N, 1..3 for det)
//   a_flat  matrix A, element (i,j) at [(i*MAX_N+j)*W +: W]
//   b_flat  matrix B, same layout
//   scalar  multiplier for the scalar op
//   r_flat  result matrix, same layout; zero outside the active n x n region
//   busy    operation executing
//   done    one-cycle completion pulse
//   ovf     some element of the last operation saturated
//   err     last command was invalid
//
// State | meaning
// IDLE  | waiting for start
// EXEC  | stepping through elements; r_fin marks the last step taken
// DONE  | done pulse; start here begins the next command immediately

module matrix_alu_seq #(
    parameter int W     = 8,
    parameter int MAX_N = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic [2:0]                 size,
    input  logic [MAX_N*MAX_N*W-1:0]   a_flat,
    input  logic [MAX_N*MAX_N*W-1:0]   b_flat,
    input  logic [W-1:0]               scalar,
    output logic [MAX_N*MAX_N*W-1:0]   r_flat,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    output logic                       err
);

    localparam int FW    = MAX_N*MAX_N*W;
    localparam int CW    = $clog2(MAX_N+1);
    localparam int ACCW  = 2*W+3;
    // wide enough for a 3x3 cofactor expansion of W-bit elements
    localparam int FULLW = 3*W+4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SCL = 3'b011;
    localparam logic [2:0] OP_DET = 3'b100;
    localparam logic [2:0] OP_TRN = 3'b101;
    localparam logic [2:0] OP_OPP = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    localparam logic signed [FULLW-1:0] SMAX = FULLW'((2**(W-1))-1);
    localparam logic signed [FULLW-1:0] SMIN = -SMAX - FULLW'(1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t                   r_state, w_state_nx;
    logic [2:0]               r_op;
    logic [CW-1:0]            r_n;
    logic [FW-1:0]            r_a, r_b;
    logic signed [W-1:0]      r_scalar;
    logic                     r_bad;
    logic [CW-1:0]            r_i, r_j, r_k;
    logic signed [ACCW-1:0]   r_acc;
    logic                     r_fin;
    logic [FW-1:0]            r_res;
    logic                     r_ovf, r_err;

    function automatic logic signed [W-1:0] elem(input logic [FW-1:0] m,
                                                 input int r, input int c);
        return $signed(m[(r*MAX_N+c)*W +: W]);
    endfunction

    logic                     w_accept, w_bad, w_single;
    logic [CW-1:0]            w_nm1;
    logic                     w_j_end, w_i_end, w_k_end;
    logic signed [W-1:0]      w_a_ij, w_a_ji, w_b_ij, w_a_ik, w_b_kj;
    logic signed [FULLW-1:0]  w_ax, w_bx, w_atx, w_sx;
    logic signed [ACCW-1:0]   w_prod, w_acc_base, w_acc_nx;
    logic signed [FULLW-1:0]  w_accx;
    logic signed [FULLW-1:0]  d00, d01, d02, d10, d11, d12, d20, d21, d22;
    logic signed [FULLW-1:0]  w_det;
    logic signed [FULLW-1:0]  w_full;
    logic                     w_sat_hi, w_sat_lo, w_sat;
    logic [W-1:0]             w_sat_val;
    int                       w_idx;

    assign w_accept = start && (r_state != S_EXEC);
    assign w_bad    = (size == 3'd0) || (int'(size) > MAX_N) ||
                      ((op == OP_DET) && (size > 3'd3));
    assign w_single = r_bad || (r_op == OP_DET) || (r_op == OP_CLR);

    assign w_nm1   = r_n - CW'(1);
    assign w_j_end = (r_j == w_nm1);
    assign w_i_end = (r_i == w_nm1);
    assign w_k_end = (r_k == w_nm1);
    assign w_idx   = int'(r_i)*MAX_N + int'(r_j);

    // operand fetch for the current (i,j,k) position
    always_comb begin
        w_a_ij = elem(r_a, int'(r_i), int'(r_j));
        w_a_ji = elem(r_a, int'(r_j), int'(r_i));
        w_b_ij = elem(r_b, int'(r_i), int'(r_j));
        w_a_ik = elem(r_a, int'(r_i), int'(r_k));
        w_b_kj = elem(r_b, int'(r_k), int'(r_j));
    end

    assign w_ax  = w_a_ij;
    assign w_bx  = w_b_ij;
    assign w_atx = w_a_ji;
    assign w_sx  = r_scalar;

    // the accumulator restarts at k=0 so each element starts from zero
    assign w_prod     = w_a_ik * w_b_kj;
    assign w_acc_base = (r_k == '0) ? '0 : r_acc;
    assign w_acc_nx   = w_acc_base + w_prod;
    assign w_accx     = w_acc_nx;

    always_comb begin
        d00 = elem(r_a, 0, 0); d01 = elem(r_a, 0, 1); d02 = elem(r_a, 0, 2);
        d10 = elem(r_a, 1, 0); d11 = elem(r_a, 1, 1); d12 = elem(r_a, 1, 2);
        d20 = elem(r_a, 2, 0); d21 = elem(r_a, 2, 1); d22 = elem(r_a, 2, 2);
        case (r_n)
            CW'(1):  w_det = d00;
            CW'(2):  w_det = d00*d11 - d01*d10;
            default: w_det = d00*(d11*d22 - d12*d21)
                           - d01*(d10*d22 - d12*d20)
                           + d02*(d10*d21 - d11*d20);
        endcase
    end

    always_comb begin
        w_full = '0;
        if (r_op == OP_DET) begin
            w_full = w_det;
        end else begin
            case (r_op)
                OP_ADD:  w_full = w_ax + w_bx;
                OP_SUB:  w_full = w_ax - w_bx;
                OP_MUL:  w_full = w_accx;
                OP_SCL:  w_full = w_ax * w_sx;
                OP_TRN:  w_full = w_atx;
                OP_OPP:  w_full = -w_ax;
                default: w_full = '0;
            endcase
        end
    end

    always_comb begin
        w_sat_hi  = (w_full > SMAX);
        w_sat_lo  = (w_full < SMIN);
        w_sat     = w_sat_hi || w_sat_lo;
        w_sat_val = w_full[W-1:0];
        if (w_sat_hi) w_sat_val = SMAX[W-1:0];
        if (w_sat_lo) w_sat_val = SMIN[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nx = S_EXEC;
            S_EXEC:  if (r_fin) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = start ? S_EXEC : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_n      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_scalar <= '0;
            r_bad    <= 1'b0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_fin    <= 1'b0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_op     <= op;
            r_n      <= CW'(size);
            r_a      <= a_flat;
            r_b      <= b_flat;
            r_scalar <= $signed(scalar);
            r_bad    <= w_bad;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_fin    <= 1'b0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_EXEC && !r_fin) begin
            if (w_single) begin
                r_fin <= 1'b1;
                if (r_bad) begin
                    r_err <= 1'b1;
                end else if (r_op == OP_DET) begin
                    r_res[W-1:0] <= w_sat_val;
                    r_ovf        <= w_sat;
                end
            end else begin
                if (r_op == OP_MUL) r_acc <= w_acc_nx;
                if (r_op != OP_MUL || w_k_end) begin
                    r_res[w_idx*W +: W] <= w_sat_val;
                    r_ovf <= r_ovf | w_sat;
                    r_k   <= '0;
                    if (w_j_end) begin
                        r_j <= '0;
                        r_i <= r_i + CW'(1);
                        if (w_i_end) r_fin <= 1'b1;
                    end else begin
                        r_j <= r_j + CW'(1);
                    end
                end else begin
                    r_k <= r_k + CW'(1);
                end
            end
        end
    end

    assign r_flat = r_res;
    assign busy   = (r_state == S_EXEC);
    assign done   = (r_state == S_DONE);
    assign ovf    = r_ovf;
    assign err    = r_err;

endmodule

// File: tb/tb_matrix_alu_seq.sv
module tb_matrix_alu_seq;

    localparam int W     = 8;
    localparam int N     = 5;
    localparam int FW    = N*N*W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [2:0]    size;
    logic [FW-1:0] a_flat, b_flat;
    logic [W-1:0]  scalar;
    logic [FW-1:0] r_flat;
    logic          busy, done, ovf, err;

    matrix_alu_seq #(.W(W), .MAX_N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .size(size),
        .a_flat(a_flat), .b_flat(b_flat), .scalar(scalar),
        .r_flat(r_flat), .busy(busy), .done(done), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string         tag;
        logic [FW-1:0] r;
        logic          ovf;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int n,
        input int v0 = 0, input int v1 = 0, input int v2 = 0,
        input int v3 = 0, input int v4 = 0, input int v5 = 0,
        input int v6 = 0, input int v7 = 0, input int v8 = 0);
        logic [FW-1:0] m;
        int v[9];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
        m = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                m[(i*N+j)*W +: W] = W'(v[i*n+j]);
        return m;
    endfunction

    // scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cycle=%0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, ".r"},     r_flat, mon_e.r);
                chk({mon_e.tag, ".ovf"},   FW'(ovf), FW'(mon_e.ovf));
                chk({mon_e.tag, ".err"},   FW'(err), FW'(mon_e.err));
                chk({mon_e.tag, ".cycle"}, FW'(cyc), FW'(mon_e.cyc));
            end
        end
    end

    task automatic issue(input string tag, input logic [2:0] o, input int n,
                         input logic [FW-1:0] a, input logic [FW-1:0] b,
                         input int sc, input logic [FW-1:0] er,
                         input logic eo, input logic ee, input int lat);
        exp_t e;
        @(negedge clk);
        op = o; size = 3'(n); a_flat = a; b_flat = b; scalar = W'(sc);
        start = 1'b1;
        @(posedge clk); #1;
        e.tag = tag; e.r = er; e.ovf = eo; e.err = ee; e.cyc = cyc + lat;
        sb.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=pending required=done", tag);
            sb.delete();
        end
        @(negedge clk);
    endtask

    logic [FW-1:0] ta, tr, id3;
    exp_t          e2;
    int            c0, dcnt;

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; size = '0;
        a_flat = '0; b_flat = '0; scalar = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.r",    r_flat, '0);
        chk("reset.busy", FW'(busy), '0);
        chk("reset.done", FW'(done), '0);
        chk("reset.ovf",  FW'(ovf), '0);
        chk("reset.err",  FW'(err), '0);

        id3 = mk(3, 1,0,0, 0,1,0, 0,0,1);

        // abort a 3x3 multiply part way
        issue("abort", 3'b010, 3, mk(3,1,2,3,4,5,6,7,8,9), id3, 0,
              mk(3,1,2,3,4,5,6,7,8,9), 1'b0, 1'b0, 28);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.r",    r_flat, '0);
        chk("abort.busy", FW'(busy), '0);
        chk("abort.done", FW'(done), '0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort.no_done", FW'(dcnt), '0);

        issue("add2", 3'b000, 2, mk(2,1,2,3,4), mk(2,5,6,7,8), 0,
              mk(2,6,8,10,12), 1'b0, 1'b0, 5);
        wait_done("add2");

        issue("mul3_id", 3'b010, 3, mk(3,1,2,3,4,5,6,7,8,9), id3, 0,
              mk(3,1,2,3,4,5,6,7,8,9), 1'b0, 1'b0, 28);
        wait_done("mul3_id");
        issue("mul2", 3'b010, 2, mk(2,1,2,3,4), mk(2,5,6,7,8), 0,
              mk(2,19,22,43,50), 1'b0, 1'b0, 9);
        wait_done("mul2");
        issue("mul2_sat", 3'b010, 2, mk(2,10,10,10,10), mk(2,10,-10,10,-10), 0,
              mk(2,127,-128,127,-128), 1'b1, 1'b0, 9);
        wait_done("mul2_sat");

        issue("add_sat", 3'b000, 1, mk(1,100), mk(1,100), 0,
              mk(1,127), 1'b1, 1'b0, 2);
        wait_done("add_sat");
        issue("opp_sat", 3'b110, 1, mk(1,-128), '0, 0,
              mk(1,127), 1'b1, 1'b0, 2);
        wait_done("opp_sat");
        issue("scl_sat", 3'b011, 1, mk(1,-64), '0, 3,
              mk(1,-128), 1'b1, 1'b0, 2);
        wait_done("scl_sat");
        issue("sub2", 3'b001, 2, mk(2,10,-5,3,0), mk(2,4,5,-3,7), 0,
              mk(2,6,-10,6,-7), 1'b0, 1'b0, 5);
        wait_done("sub2");
        issue("scl2", 3'b011, 2, mk(2,1,-2,3,4), '0, 5,
              mk(2,5,-10,15,20), 1'b0, 1'b0, 5);
        wait_done("scl2");
        issue("opp2", 3'b110, 2, mk(2,1,-2,3,0), '0, 0,
              mk(2,-1,2,-3,0), 1'b0, 1'b0, 5);
        wait_done("opp2");

        issue("det3_zero", 3'b100, 3, mk(3,2,0,1,1,3,2,1,1,1), '0, 0,
              mk(1,0), 1'b0, 1'b0, 2);
        wait_done("det3_zero");
        issue("det3", 3'b100, 3, mk(3,2,0,1,1,3,2,1,1,2), '0, 0,
              mk(1,6), 1'b0, 1'b0, 2);
        wait_done("det3");
        issue("det2", 3'b100, 2, mk(2,1,2,3,4), '0, 0,
              mk(1,-2), 1'b0, 1'b0, 2);
        wait_done("det2");
        issue("det1", 3'b100, 1, mk(1,-7), '0, 0,
              mk(1,-7), 1'b0, 1'b0, 2);
        wait_done("det1");
        issue("det2_sat", 3'b100, 2, mk(2,100,0,0,100), '0, 0,
              mk(1,127), 1'b1, 1'b0, 2);
        wait_done("det2_sat");
        issue("det4_err", 3'b100, 4, mk(3,1,2,3,4,5,6,7,8,9), '0, 0,
              '0, 1'b0, 1'b1, 2);
        wait_done("det4_err");

        ta = '0; tr = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ta[(i*N+j)*W +: W] = W'(10*i + j);
                tr[(i*N+j)*W +: W] = W'(10*j + i);
            end
        issue("trn5", 3'b101, 5, ta, '0, 0, tr, 1'b0, 1'b0, 26);
        wait_done("trn5");
        issue("size6_err", 3'b101, 6, ta, '0, 0, '0, 1'b0, 1'b1, 2);
        wait_done("size6_err");
        issue("size0_err", 3'b000, 0, ta, ta, 0, '0, 1'b0, 1'b1, 2);
        wait_done("size0_err");

        // start held high: one accept, then a re-accept in the DONE cycle
        @(negedge clk);
        op = 3'b000; size = 3'd2; a_flat = mk(2,1,2,3,4); b_flat = mk(2,5,6,7,8);
        start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        e2.tag = "held1"; e2.r = mk(2,6,8,10,12); e2.ovf = 1'b0; e2.err = 1'b0;
        e2.cyc = c0 + 5;
        sb.push_back(e2);
        repeat (5) @(posedge clk);
        #1;
        e2.tag = "held2"; e2.cyc = c0 + 11;
        sb.push_back(e2);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("held");

        // inputs changed during EXEC must not disturb the result
        issue("latch", 3'b000, 2, mk(2,1,2,3,4), mk(2,5,6,7,8), 0,
              mk(2,6,8,10,12), 1'b0, 1'b0, 5);
        a_flat = {(FW/8){8'h55}};
        b_flat = {(FW/8){8'h33}};
        op = 3'b110;
        wait_done("latch");

        issue("clear", 3'b111, 3, mk(3,1,2,3,4,5,6,7,8,9), id3, 0,
              '0, 1'b0, 1'b0, 2);
        wait_done("clear");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
